// File: rtl/mod_exp_pkg.sv
// Shared types and sizing for the modular-exponentiation sequencer.
package mod_exp_pkg;

  localparam int WIDTH   = 256;
  localparam int IDX_W   = 8;
  localparam int TIMEOUT = 31;
  localparam int MP_W    = 32;
  localparam int TMO_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    LOAD,
    WAIT,
    NEXT,
    DONE
  } state_t;

endpackage

// File: rtl/mod_exp_ctrl_if.sv
// Operand/result bus between the sequencer (master) and the Montgomery multiplier (slave).
interface mod_exp_ctrl_if;
  import mod_exp_pkg::*;

  logic             mm_enable;
  logic [WIDTH-1:0] mm_modulos;
  logic [MP_W-1:0]  mm_mp;
  logic [WIDTH-1:0] mm_multiplicand;
  logic [WIDTH-1:0] mm_indata;
  logic             mm_pow_bit;
  logic             mm_endflag;
  logic [WIDTH-1:0] mm_result;

  modport master (
    output mm_enable, mm_modulos, mm_mp, mm_multiplicand, mm_indata, mm_pow_bit,
    input  mm_endflag, mm_result
  );

  modport slave (
    input  mm_enable, mm_modulos, mm_mp, mm_multiplicand, mm_indata, mm_pow_bit,
    output mm_endflag, mm_result
  );

endinterface

// File: rtl/mod_exp_timeout.sv
// Saturating cycle counter bounding how long the sequencer waits on the multiplier.
module mod_exp_timeout
  import mod_exp_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expire
);

  logic [TMO_W-1:0] count;

  assign expire = (count == TMO_W'(TIMEOUT));

  // NOTE: sequential state uses non-blocking assignments so every reader sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      count <= '0;
    end else if (en && !expire) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mod_exp_ctrl.sv
// Left-to-right binary modular exponentiation in the Montgomery domain, one MM op per exponent bit.
// Optional: define MODEXP_LZ_SKIP_EN to skip leading zero exponent bits (zero exponent issues no MM op).
module mod_exp_ctrl
  import mod_exp_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] modulus,
  input  logic [MP_W-1:0]  mp,
  input  logic [WIDTH-1:0] base_mont,
  input  logic [WIDTH-1:0] one_mont,
  input  logic [WIDTH-1:0] exponent,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] result,
  mod_exp_ctrl_if.master   mm
);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] e;
  logic             tmo_clear;
  logic             tmo_en;
  logic             tmo_expire;

  assign tmo_clear = (state == LOAD);
  assign tmo_en    = (state == WAIT);

  mod_exp_timeout u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tmo_clear),
    .en     (tmo_en),
    .expire (tmo_expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the wide datapath is reset as well, so an aborted run never leaves stale operands or results visible.
      state              <= IDLE;
      idx                <= IDX_W'(WIDTH - 1);
      acc                <= '0;
      e                  <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      error              <= 1'b0;
      result             <= '0;
      mm.mm_enable       <= 1'b0;
      mm.mm_modulos      <= '0;
      mm.mm_mp           <= '0;
      mm.mm_multiplicand <= '0;
      mm.mm_indata       <= '0;
      mm.mm_pow_bit      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mm.mm_modulos <= modulus;
            mm.mm_mp      <= mp;
            mm.mm_indata  <= base_mont;
            e             <= exponent;
            acc           <= one_mont;
            idx           <= IDX_W'(WIDTH - 1);
            error         <= 1'b0;
            busy          <= 1'b1;
`ifdef MODEXP_LZ_SKIP_EN
            state         <= SCAN;
`else
            state         <= LOAD;
`endif
          end
        end
`ifdef MODEXP_LZ_SKIP_EN
        SCAN: begin
          // A nonzero exponent guarantees a set bit is found before idx underflows.
          if (e == '0) begin
            state <= DONE;
          end else if (!e[idx]) begin
            idx <= idx - 1'b1;
          end else begin
            state <= LOAD;
          end
        end
`endif
        LOAD: begin
          mm.mm_enable       <= 1'b0;
          mm.mm_multiplicand <= acc;
          mm.mm_pow_bit      <= e[idx];
          state              <= WAIT;
        end
        WAIT: begin
          mm.mm_enable <= 1'b1;
          if (mm.mm_endflag) begin
            acc   <= mm.mm_result;
            state <= NEXT;
          end else if (tmo_expire) begin
            error        <= 1'b1;
            mm.mm_enable <= 1'b0;
            state        <= DONE;
          end
        end
        NEXT: begin
          if (idx == '0) begin
            state <= DONE;
          end else begin
            idx   <= idx - 1'b1;
            state <= LOAD;
          end
        end
        DONE: begin
          result       <= acc;
          done         <= 1'b1;
          busy         <= 1'b0;
          mm.mm_enable <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Scoreboard bench for mod_exp_ctrl with a behavioural MM model (N=23, latencies 9/18).
module tb_mod_exp_ctrl;
  import mod_exp_pkg::*;

  localparam int BOUND = 20000;
  // 2^256 mod 23 = 8 (2^11 = 1 mod 23), and 8*3 = 1 mod 23, so R^-1 mod 23 = 3.
  localparam logic [63:0] N_VAL = 64'd23;
  localparam logic [63:0] RINV  = 64'd3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] modulus, base_mont, one_mont, exponent;
  logic [MP_W-1:0]  mp, mp_val;
  logic             busy, done, error;
  logic [WIDTH-1:0] result;

  mod_exp_ctrl_if mm ();

  mod_exp_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .modulus   (modulus),
    .mp        (mp),
    .base_mont (base_mont),
    .one_mont  (one_mont),
    .exponent  (exponent),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .result    (result),
    .mm        (mm)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [MP_W-1:0] neg_inv(input logic [MP_W-1:0] n);
    logic [MP_W-1:0] x;
    x = n;
    repeat (5) x = x * (32'd2 - n * x);
    return -x;
  endfunction

  function automatic logic [WIDTH-1:0] mm_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic pow);
    logic [63:0] t;
    t = (a[63:0] * a[63:0] * RINV) % N_VAL;
    if (pow) t = (t * b[63:0] * RINV) % N_VAL;
    return WIDTH'(t);
  endfunction

  // ---------------- behavioural Montgomery multiplier ----------------
  bit   hang = 1'b0;
  bit   prev_en = 1'b0;
  bit   armed = 1'b0;
  int   mm_cnt = 0;
  int   op_count = 0;
  int   pow1_count = 0;
  logic pow_log [0:4095];

  always @(posedge clk) begin
    prev_en        <= mm.mm_enable;
    mm.mm_endflag  <= 1'b0;
    if (mm.mm_enable && !prev_en) begin
      op_count              <= op_count + 1;
      pow_log[op_count % 4096] <= mm.mm_pow_bit;
      if (mm.mm_pow_bit) pow1_count <= pow1_count + 1;
    end
    if (!mm.mm_enable) begin
      mm_cnt <= 0;
      armed  <= 1'b1;
    end else if (armed && !hang) begin
      if (mm_cnt + 1 == (mm.mm_pow_bit ? 18 : 9)) begin
        mm.mm_endflag <= 1'b1;
        mm.mm_result  <= mm_op(mm.mm_multiplicand, mm.mm_indata, mm.mm_pow_bit);
        armed         <= 1'b0;
        mm_cnt        <= 0;
      end else begin
        mm_cnt <= mm_cnt + 1;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  typedef struct {
    logic [WIDTH-1:0] res;
    logic             err;
    string            name;
  } sb_t;
  sb_t sb_q[$];

  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", done, 1'b0);
      end else begin
        sb_t s;
        s = sb_q.pop_front();
        check({s.name, "_result"}, result, s.res);
        check({s.name, "_error"}, error, WIDTH'(s.err));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run(input logic [WIDTH-1:0] e, input logic [WIDTH-1:0] exp_res, input logic exp_err,
                     input string nm, input bit extra, output int ops, output int cycles);
    int ops0;
    bit busy_low;
    sb_q.push_back('{res: exp_res, err: exp_err, name: nm});
    ops0     = op_count;
    busy_low = 1'b0;
    @(negedge clk);
    exponent = e;
    start    = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cycles = 1;
    check({nm, "_err_clr"}, error, 1'b0);
    while (!done && cycles < BOUND) begin
      if (!busy) busy_low = 1'b1;
      if (extra && cycles == 20) begin
        start    = 1'b1;
        exponent = 256'd5;
      end
      if (extra && cycles == 21) start = 1'b0;
      @(negedge clk);
      cycles++;
    end
    check({nm, "_done_seen"}, done, 1'b1);
    check({nm, "_busy_held"}, busy_low, 1'b0);
    ops = op_count - ops0;
    @(negedge clk);
  endtask

  initial begin
    int ops, ops_a, cyc, o0, p0, w;
    mp_val    = neg_inv(32'd23);
    modulus   = 256'd23;
    mp        = mp_val;
    one_mont  = 256'd8;   // 1*R mod 23
    base_mont = 256'd17;  // 5*R mod 23
    exponent  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_result", result, '0);
    check("rst_mm_enable", mm.mm_enable, 1'b0);
    check("rst_mm_mult", mm.mm_multiplicand, '0);
    check("rst_mm_modulos", mm.mm_modulos, '0);
    rst_n = 1'b1;

    // 5^3 = 10 mod 23, Montgomery form 10*8 mod 23 = 11
    run(256'd3, 256'd11, 1'b0, "exp3", 1'b0, ops_a, cyc);
`ifdef MODEXP_LZ_SKIP_EN
    check("exp3_ops", ops_a, 2);
`else
    check("exp3_ops", ops_a, 256);
`endif
    check("mm_modulos", mm.mm_modulos, 256'd23);
    check("mm_mp", mm.mm_mp, mp_val);
    check("mm_indata", mm.mm_indata, 256'd17);

    run('0, 256'd8, 1'b0, "exp0", 1'b0, ops, cyc);
`ifdef MODEXP_LZ_SKIP_EN
    check("exp0_ops", ops, 0);
    check("exp0_fast", (cyc <= 3), 1'b1);
`else
    check("exp0_ops", ops, 256);
`endif

    // 5^(2^255) mod 23 = 9, Montgomery form 9*8 mod 23 = 3
    o0 = op_count;
    p0 = pow1_count;
    run({1'b1, 255'b0}, 256'd3, 1'b0, "exp_msb", 1'b0, ops, cyc);
    check("exp_msb_ops", ops, 256);
    check("exp_msb_first_pow", pow_log[o0 % 4096], 1'b1);
    check("exp_msb_pow1_ops", pow1_count - p0, 1);

    hang = 1'b1;
    run(256'd3, 256'd8, 1'b1, "timeout", 1'b0, ops, cyc);
    hang = 1'b0;
    check("timeout_ops", ops, 1);
    check("timeout_mm_enable", mm.mm_enable, 1'b0);

    // 5^5 = 20 mod 23, Montgomery form 20*8 mod 23 = 22
    run(256'd5, 256'd22, 1'b0, "after_tmo", 1'b0, ops, cyc);

    o0 = op_count;
    @(negedge clk);
    exponent = {1'b1, 255'b0};
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w     = 0;
    while ((op_count - o0) < 10 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("rst_at_op10", op_count - o0, 10);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_mm_enable", mm.mm_enable, 1'b0);
    check("abort_result", result, '0);
    check("abort_done", done, 1'b0);
    check("abort_mm_mult", mm.mm_multiplicand, '0);
    rst_n = 1'b1;
    @(negedge clk);

    run(256'd5, 256'd22, 1'b0, "after_rst", 1'b0, ops, cyc);

    run(256'd3, 256'd11, 1'b0, "busy_start", 1'b1, ops, cyc);
    check("busy_start_ops", ops, ops_a);

    repeat (2) @(negedge clk);
    check("sb_drain", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
